div_radix2: RTL
===============

# div_radix2

Multi-cycle radix-2 restoring divider for the E stage, executing DIV/DIVU. It drives the pipeline hold request that the hazard unit turns into stallF–stallW. It holds the 64-bit HI/LO result until the E stage actually advances, so that d_stall, i_stall or gap_stall cannot overlap the divide's final cycle and lose the result. An exception flush annuls it at any point.

## Interface
Parameters:
- DATA_W, 32, operand width; the quotient and remainder are DATA_W each.
- ITERS, 32, iterations per divide; must equal DATA_W.

Ports:
- clk  in  1  single clock; every state update is on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start_i  in  1  E-stage instruction is DIV/DIVU and valid.
- signed_i  in  1  1 selects DIV (signed), 0 selects DIVU.
- opdata1_i  in  DATA_W  dividend (rs value after forwarding).
- opdata2_i  in  DATA_W  divisor (rt value after forwarding).
- annul_i  in  1  exception flush (except_typeM != 0); cancels the operation.
- adv_i  in  1  E stage advances this cycle (stallE low).
- stall_div_o  out  1  hold request to the hazard unit.
- ready_o  out  1  result valid.
- result_o  out  2*DATA_W  {HI = remainder, LO = quotient}.

## Operation
- States:
  - IDLE: no divide in progress.
  - ZERO: one-cycle divide-by-zero path.
  - BUSY: iterating.
  - DONE: result held.
- Transitions:
  - IDLE -> ZERO when start_i & !annul_i & divisor == 0.
  - IDLE -> BUSY when start_i & !annul_i & divisor != 0. Operands, signed_i and sign bits are latched on this edge, and cnt is set to 0.
  - BUSY: cnt increments once per cycle. BUSY -> DONE on the edge where cnt == ITERS-1.
  - ZERO -> DONE on the next edge.
  - DONE -> IDLE when adv_i. start_i is ignored while in DONE, because the same instruction is still in E.
  - Any state -> IDLE when annul_i. annul_i has priority over every other transition.
- Signed handling:
  - Divide the magnitudes |a| and |b|.
  - Negate the quotient when sign(a) ^ sign(b).
  - Negate the remainder when sign(a).
  - Magnitudes use DATA_W+1 bits internally so that 0x80000000 is representable.
- Iteration, on a 2*DATA_W+1 bit partial register: shift left by 1; if upper DATA_W+1 bits >= |b|, subtract |b| and set the LSB.
- Overflow case: 0x80000000 / 0xFFFFFFFF signed gives LO = 0x80000000, HI = 0. This is not trapped.
- Divide by zero: LO = 0xFFFFFFFF, HI = dividend (raw opdata1), regardless of signed_i.
- stall_div_o = !annul_i & ((IDLE & start_i) | BUSY | ZERO). It is combinational and never asserted in DONE.
- ready_o = (state == DONE). It is a registered state decode.
- result_o is registered on the edge entering DONE. It is stable through DONE and keeps its last value afterwards.

## Timing
- Reset: state = IDLE, cnt = 0, result_o = 0, ready_o = 0, stall_div_o = 0 with start_i low.
- Non-zero divisor, start_i first seen in cycle 0:
  - stall_div_o is high in cycles 0..32 (33 cycles).
  - ready_o is high from cycle 33.
- Zero divisor: stall_div_o is high in cycles 0..1; ready_o is high from cycle 2.
- DONE persists while adv_i is low; stall_div_o stays low in that time.
- Back-to-back divides: DONE leaves on the adv_i edge. A new start_i in the next cycle is accepted from IDLE with no bubble.
- annul_i in any cycle: stall_div_o drops in that same cycle. The state is IDLE after the edge, and ready_o does not assert for the cancelled operation.
- rst asserted mid-BUSY: immediate return to IDLE; result_o is cleared.
- Operand inputs may change after the start edge without effect.

## Structure
- Shared package (cpu_defs):
  - state enum {IDLE, ZERO, BUSY, DONE};
  - DIV_W = 32;
  - DIV_ZERO_LO = 32'hFFFFFFFF.
- Sub-module div_step: purely combinational single iteration. Inputs are the partial register and |b|; outputs are the next partial register. It is instantiated once.
- The top level holds the FSM, cnt (5 bits, log2 ITERS), the sign/magnitude prep and the final sign fix.

## Test plan
- DIVU 100 / 7, adv_i high throughout -> stall high 33 cycles; cycle 33 ready_o = 1, LO = 14, HI = 2; IDLE the next cycle.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 0x12345678 / 0 -> stall high 2 cycles; ready_o in cycle 2; LO = 0xFFFFFFFF, HI = 0x12345678.
- Start, then annul_i in BUSY cycle 10 -> stall_div_o low the same cycle; IDLE next; ready_o never asserts. Repeat with rst in place of annul_i: same outcome and result_o = 0.
- Reach DONE with adv_i low for 5 cycles and start_i held high -> result stable, no restart, stall low. adv_i pulse -> IDLE. A new start (DIVU 9 / 3) the following cycle -> LO = 3, HI = 0 after 33 cycles.

Source files
------------

// File: rtl/div_radix2_pkg.sv
// Shared divider definitions: FSM encoding, default width and the divide-by-zero quotient.
package cpu_defs;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ZERO = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int          DIV_W       = 32;
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_radix2_step.sv
// One restoring-division iteration on the {remainder, quotient} partial register.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [2*DATA_W:0] part_i,
    input  logic [DATA_W:0]   bmag_i,
    output logic [2*DATA_W:0] part_o
);

    logic [2*DATA_W:0] shifted;
    logic [DATA_W:0]   upper;

    always_comb begin
        shifted = {part_i[2*DATA_W-1:0], 1'b0};
        upper   = shifted[2*DATA_W:DATA_W];
        part_o  = shifted;
        if (upper >= bmag_i)
            part_o = {upper - bmag_i, shifted[DATA_W-1:1], 1'b1};
    end

endmodule

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring DIV/DIVU for the E stage; holds {HI,LO} until the stage advances.
module div_radix2
    import cpu_defs::*;
#(
    parameter int DATA_W = DIV_W,
    parameter int ITERS  = DIV_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                annul_i,
    input  logic                adv_i,
    output logic                stall_div_o,
    output logic                ready_o,
    output logic [2*DATA_W-1:0] result_o
);

    localparam int CNT_W = $clog2(ITERS);

    div_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W:0]   part_q;
    logic [DATA_W:0]     bmag_q;
    logic [DATA_W-1:0]   a_q;
    logic                negq_q, negr_q, ready_q;
    logic [2*DATA_W-1:0] result_q;

    logic [DATA_W:0]     a_ext, b_ext, amag_d, bmag_d;
    logic [2*DATA_W:0]   step_out;
    logic [DATA_W-1:0]   q_fix_d, r_fix_d;
    logic                unused_top;

    // Sign-extend to DATA_W+1 so the most negative dividend has a representable magnitude.
    always_comb begin
        a_ext  = {signed_i & opdata1_i[DATA_W-1], opdata1_i};
        b_ext  = {signed_i & opdata2_i[DATA_W-1], opdata2_i};
        amag_d = a_ext[DATA_W] ? -a_ext : a_ext;
        bmag_d = b_ext[DATA_W] ? -b_ext : b_ext;
    end

    div_step #(.DATA_W(DATA_W)) u_step (
        .part_i (part_q),
        .bmag_i (bmag_q),
        .part_o (step_out)
    );

    always_comb begin
        q_fix_d = negq_q ? -step_out[DATA_W-1:0]          : step_out[DATA_W-1:0];
        r_fix_d = negr_q ? -step_out[2*DATA_W-1:DATA_W]   : step_out[2*DATA_W-1:DATA_W];
    end

    assign unused_top = step_out[2*DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            part_q   <= '0;
            bmag_q   <= '0;
            a_q      <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else if (annul_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    a_q   <= opdata1_i;
                    cnt_q <= '0;
                    if (opdata2_i == '0) begin
                        state_q <= ZERO;
                    end else begin
                        state_q <= BUSY;
                        part_q  <= {{DATA_W{1'b0}}, amag_d};
                        bmag_q  <= bmag_d;
                        negq_q  <= a_ext[DATA_W] ^ b_ext[DATA_W];
                        negr_q  <= a_ext[DATA_W];
                    end
                end
                ZERO: begin
                    state_q  <= DONE;
                    ready_q  <= 1'b1;
                    result_q <= {a_q, DATA_W'(DIV_ZERO_LO)};
                end
                BUSY: begin
                    part_q <= step_out;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITERS-1)) begin
                        state_q  <= DONE;
                        ready_q  <= 1'b1;
                        result_q <= {r_fix_d, q_fix_d};
                    end
                end
                // start_i still belongs to the finished instruction here, so only adv_i matters.
                DONE: if (adv_i) begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall_div_o = !annul_i &
                         (((state_q == IDLE) & start_i) | (state_q == BUSY) | (state_q == ZERO));
    assign ready_o     = ready_q;
    assign result_o    = result_q;

endmodule
